// File: rtl/sec32_encoder.sv
// sec32_encoder: 2-stage valid/ready pipeline producing 8 SEC check bits per 32-bit word.
// Optional single-bit error injection is enabled by defining SEC32_ENC_ERR_INJECT_EN.
module sec32_encoder (
   input  logic        CK,
   input  logic        RST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_check,
`ifdef SEC32_ENC_ERR_INJECT_EN
   input  logic        inj_req,
   input  logic [5:0]  inj_pos,
   output logic        inj_done,
`endif
   output logic [15:0] word_cnt
);
   localparam logic [31:0] MASK [8] = '{
      32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
      32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
   };
   logic        v1_q, v2_q, ld1, ld2;
   logic [31:0] d1_q, data_q, data_d;
   logic [7:0]  lo_q, hi_q, p_lo_d, p_hi_d, check_q, check_d;
   logic [15:0] cnt_q;
   logic [39:0] flip;
   assign ld2       = ~v2_q | out_ready;
   assign ld1       = ~v1_q | ld2;
   assign in_ready  = ld1;
   assign out_valid = v2_q;
   assign out_data  = data_q;
   assign out_check = check_q;
   assign word_cnt  = cnt_q;
   // Stage 1 keeps separate half-word parities so stage 2 only needs one XOR per check bit.
   always_comb begin
      p_lo_d = '0;
      p_hi_d = '0;
      for (int k = 0; k < 8; k++) begin
         p_lo_d[k] = ^(in_data[15:0] & MASK[k][15:0]);
         p_hi_d[k] = ^(in_data[31:16] & MASK[k][31:16]);
      end
   end
   assign data_d  = d1_q ^ flip[31:0];
   assign check_d = lo_q ^ hi_q ^ flip[39:32];
`ifdef SEC32_ENC_ERR_INJECT_EN
   logic       armed_q, done_q, apply;
   logic [5:0] pos_q;
   assign apply    = ld2 & v1_q & armed_q;
   assign flip     = apply ? (40'd1 << pos_q) : '0;
   assign inj_done = done_q;
   // A request in the same cycle as a consuming load re-arms for the following load.
   always_ff @(posedge CK) begin
      if (RST) begin
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         pos_q   <= '0;
      end else begin
         done_q <= apply;
         if (inj_req && inj_pos < 6'd40) begin
            armed_q <= 1'b1;
            pos_q   <= inj_pos;
         end else if (apply) begin
            armed_q <= 1'b0;
         end
      end
   end
`else
   assign flip = '0;
`endif
   always_ff @(posedge CK) begin
      if (RST) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         d1_q    <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         data_q  <= '0;
         check_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (ld1) v1_q <= in_valid;
         if (ld1 && in_valid) begin
            d1_q <= in_data;
            lo_q <= p_lo_d;
            hi_q <= p_hi_d;
         end
         if (ld2) v2_q <= v1_q;
         if (ld2 && v1_q) begin
            data_q  <= data_d;
            check_q <= check_d;
         end
         if (v2_q && out_ready) cnt_q <= cnt_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_sec32_encoder.sv
// tb_sec32_encoder: directed and randomized checks of sec32_encoder against a set-based parity model.
// Injection scenarios are compiled in when SEC32_ENC_ERR_INJECT_EN is defined.
module tb_sec32_encoder;
   logic        CK = 1'b0, RST = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic [15:0] word_cnt;
   int tests = 0, fails = 0;
`ifdef SEC32_ENC_ERR_INJECT_EN
   logic       inj_req = 1'b0, inj_done;
   logic [5:0] inj_pos = '0;
`endif
   localparam logic [31:0] BW [4] = '{32'h00000001, 32'h00010000, 32'hFFFFFFFF, 32'h80000000};
   localparam logic [7:0]  BC [4] = '{8'h51, 8'h15, 8'h00, 8'h8A};

   sec32_encoder dut (
      .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_check(out_check),
`ifdef SEC32_ENC_ERR_INJECT_EN
      .inj_req(inj_req), .inj_pos(inj_pos), .inj_done(inj_done),
`endif
      .word_cnt(word_cnt)
   );

   always #5 CK = ~CK;

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   // Parity built from the listed index sets, walked group by group.
   function automatic logic [7:0] ref_check(input logic [31:0] d);
      logic [7:0] c = '0;
      for (int i = 0; i < 4; i++) begin
         c[0] ^= d[4*i];    c[1] ^= d[4*i+1];  c[2] ^= d[4*i+2];  c[3] ^= d[4*i+3];
         c[4] ^= d[16+4*i]; c[5] ^= d[17+4*i]; c[6] ^= d[18+4*i]; c[7] ^= d[19+4*i];
         c[2] ^= d[16+i] ^ d[24+i]; c[3] ^= d[20+i] ^ d[28+i];
         c[6] ^= d[i] ^ d[8+i];     c[7] ^= d[4+i] ^ d[12+i];
      end
      for (int i = 0; i < 8; i++) begin
         c[0] ^= d[16+i]; c[1] ^= d[24+i]; c[4] ^= d[i]; c[5] ^= d[8+i];
      end
      return c;
   endfunction

   task automatic tick;
      @(posedge CK);
      #1;
   endtask

   task automatic do_reset;
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick;
      tick;
      RST = 1'b0;
   endtask

   task automatic test_reset;
      RST = 1'b1; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
      tick;
      @(negedge CK);
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || out_check !== 8'h0 || word_cnt !== 16'h0) begin
         fails++;
         $display("FAIL reset_state: rdy=%b vld=%b data=%h chk=%h cnt=%h, need rdy=1 vld=0 zeros",
                  in_ready, out_valid, out_data, out_check, word_cnt);
      end
      tick;
      RST = 1'b0; in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CK);
         tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_discard: cycle %0d vld=%b rdy=%b, need vld=0 rdy=1", c, out_valid, in_ready);
         end
         tick;
      end
   endtask

   task automatic test_zero_latency;
      do_reset;
      in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      @(negedge CK);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL latency_early: out_valid=%b after 1 edge, need 0", out_valid);
      end
      tick;
      @(negedge CK);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h0 || out_check !== 8'h00 || word_cnt !== 16'd0) begin
         fails++;
         $display("FAIL latency_zero: vld=%b data=%h chk=%h cnt=%0d, need 1/0/00/0", out_valid, out_data, out_check, word_cnt);
      end
      tick;
      tests++;
      if (word_cnt !== 16'd1) begin
         fails++;
         $display("FAIL cnt_first: word_cnt=%0d, need 1", word_cnt);
      end
   endtask

   task automatic test_back_to_back;
      int got = 0;
      do_reset;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (c < 4);
         in_data  = BW[c%4];
         @(negedge CK);
         if (out_valid) begin
            if (got < 4) begin
               tests++;
               if (out_data !== BW[got] || out_check !== BC[got] || c != got + 2) begin
                  fails++;
                  $display("FAIL b2b_word%0d: data=%h chk=%h at cycle %0d, need %h/%h at cycle %0d",
                           got, out_data, out_check, c, BW[got], BC[got], got + 2);
               end
            end
            got++;
         end
         tick;
      end
      tests++;
      if (got != 4 || word_cnt !== 16'd4) begin
         fails++;
         $display("FAIL b2b_count: got %0d words cnt=%0d, need 4/4", got, word_cnt);
      end
   endtask

   task automatic test_stall;
      logic [31:0] ws [3];
      int acc = 0;
      for (int i = 0; i < 3; i++) ws[i] = $urandom;
      do_reset;
      for (int c = 0; c < 5; c++) begin
         in_valid = (acc < 3);
         in_data  = ws[acc < 3 ? acc : 2];
         @(negedge CK);
         tests++;
         if (in_ready !== (acc < 2)) begin
            fails++;
            $display("FAIL stall_ready: cycle %0d in_ready=%b, need %b", c, in_ready, acc < 2);
         end
         if (c >= 2) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== ws[0] || out_check !== ref_check(ws[0])) begin
               fails++;
               $display("FAIL stall_hold: cycle %0d vld=%b data=%h chk=%h, need 1/%h/%h",
                        c, out_valid, out_data, out_check, ws[0], ref_check(ws[0]));
            end
         end
         if (in_valid && in_ready) acc++;
         tick;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_valid = (acc < 3);
         in_data  = ws[2];
         @(negedge CK);
         tests++;
         if (c < 3 && (out_valid !== 1'b1 || out_data !== ws[c] || out_check !== ref_check(ws[c]))) begin
            fails++;
            $display("FAIL release_word%0d: vld=%b data=%h chk=%h, need 1/%h/%h",
                     c, out_valid, out_data, out_check, ws[c], ref_check(ws[c]));
         end else if (c == 3 && out_valid !== 1'b0) begin
            fails++;
            $display("FAIL release_extra: out_valid=%b, need 0", out_valid);
         end
         if (in_valid && in_ready) acc++;
         tick;
      end
      tests++;
      if (word_cnt !== 16'd3) begin
         fails++;
         $display("FAIL release_cnt: word_cnt=%0d, need 3", word_cnt);
      end
   endtask

   task automatic test_reset_midstream;
      do_reset;
      in_valid = 1'b1;
      in_data = 32'hA5A5A5A5;
      tick;
      in_data = 32'h5A5A5A5A;
      tick;
      RST = 1'b1; in_data = 32'h12345678;
      tick;
      RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CK);
         tests++;
         if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset: cycle %0d vld=%b cnt=%0d, need 0/0", c, out_valid, word_cnt);
         end
         tick;
      end
   endtask

   task automatic test_random;
      logic [31:0] q[$];
      logic [31:0] pd, sent;
      logic [7:0]  pc;
      logic [15:0] cnt = '0;
      bit stall = 0, inx, outx;
      do_reset;
      for (int c = 0; c < 2000; c++) begin
         in_valid  = (c < 1980) && ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         out_ready = (c >= 1980) || ($urandom_range(0, 2) != 0);
         @(negedge CK);
         tests++;
         if (in_ready !== (q.size() < 2 || out_ready)) begin
            fails++;
            $display("FAIL rnd_ready: cycle %0d in_ready=%b occupancy=%0d", c, in_ready, q.size());
         end
         if (stall) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== pd || out_check !== pc) begin
               fails++;
               $display("FAIL rnd_stable: cycle %0d vld=%b data=%h chk=%h, need 1/%h/%h", c, out_valid, out_data, out_check, pd, pc);
            end
         end
         if (out_valid) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rnd_spurious: cycle %0d data=%h with no word outstanding", c, out_data);
            end else if (out_data !== q[0] || out_check !== ref_check(q[0])) begin
               fails++;
               $display("FAIL rnd_word: cycle %0d data=%h chk=%h, need %h/%h", c, out_data, out_check, q[0], ref_check(q[0]));
            end
         end
         inx = in_valid && in_ready;
         outx = out_valid && out_ready;
         stall = out_valid && !out_ready;
         pd = out_data;
         pc = out_check;
         sent = in_data;
         tick;
         if (outx && q.size() > 0) begin
            void'(q.pop_front());
            cnt++;
         end
         if (inx) q.push_back(sent);
         tests++;
         if (word_cnt !== cnt) begin
            fails++;
            $display("FAIL rnd_cnt: cycle %0d word_cnt=%0d, need %0d", c, word_cnt, cnt);
         end
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL rnd_drain: %0d words never emerged", q.size());
      end
   endtask

   task automatic test_wrap;
      int n = 0;
      do_reset;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int c = 0; c < 70000 && n < 65537; c++) begin
         in_data = c;
         @(negedge CK);
         if (out_valid && out_ready) n++;
         tick;
         if (n == 65535) begin
            tests++;
            if (word_cnt !== 16'hFFFF) begin
               fails++;
               $display("FAIL wrap_max: word_cnt=%h, need ffff", word_cnt);
            end
         end
      end
      tests++;
      if (n != 65537 || word_cnt !== 16'h0001) begin
         fails++;
         $display("FAIL wrap: %0d transfers word_cnt=%h, need 65537/0001", n, word_cnt);
      end
   endtask

`ifdef SEC32_ENC_ERR_INJECT_EN
   task automatic test_inject;
      int seen, done;
      logic [5:0]  pos [2] = '{6'd5, 6'd45};
      logic [31:0] ed  [2] = '{32'h00000020, 32'h00000000};
      do_reset;
      for (int t = 0; t < 2; t++) begin
         seen = 0;
         done = 0;
         inj_req = 1'b1; inj_pos = pos[t];
         tick;
         inj_req = 1'b0; out_ready = 1'b1;
         for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0);
            in_data  = 32'h0;
            @(negedge CK);
            if (inj_done === 1'b1) done++;
            if (out_valid) begin
               seen++;
               tests++;
               if (out_data !== ed[t] || out_check !== 8'h00) begin
                  fails++;
                  $display("FAIL inject_word pos=%0d: data=%h chk=%h, need %h/00", pos[t], out_data, out_check, ed[t]);
               end
            end
            tick;
         end
         tests++;
         if (seen != 1 || done != (t == 0 ? 1 : 0)) begin
            fails++;
            $display("FAIL inject_done pos=%0d: words=%0d pulses=%0d, need 1/%0d", pos[t], seen, done, t == 0 ? 1 : 0);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_zero_latency;
      test_back_to_back;
      test_stall;
      test_reset_midstream;
      test_random;
`ifdef SEC32_ENC_ERR_INJECT_EN
      test_inject;
`endif
      test_wrap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
